// File: rtl/bcd_pkg.sv
// Shared types, constants and the digit-count helper for the binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, FINISH} estado_t;

  localparam int BCD_DIGIT_W = 4;

  // Decimal digits needed to print 2^bin_w-1.
  function automatic int bcd_digitos_min(input int bin_w);
    longint unsigned v;
    int n;
    v = (64'd1 << bin_w) - 64'd1;
    n = 0;
    do begin
      v = v / 64'd10;
      n = n + 1;
    end while (v != 64'd0);
    return n;
  endfunction

endpackage

// File: rtl/bcd_ajuste_digito.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_ajuste_digito (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bcd_convertidor_param.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), BIN_W+1 clocks per word.
// Signed input handling is built only when BCD_SIGNO_EN is defined.
module bcd_convertidor_param
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        inicio,
  input  logic [BIN_W-1:0]            bin,
  input  logic                        con_signo,
  output logic [BCD_DIGIT_W*DIGITS-1:0] codigo_BCD,
  output logic                        negativo,
  output logic                        ocupado,
  output logic                        done
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int ACC_W = BCD_DIGIT_W * DIGITS;

  if (BIN_W < 2 || BIN_W > 32 || DIGITS < bcd_digitos_min(BIN_W)) begin : g_param_err
    $error("bcd_convertidor_param: illegal BIN_W/DIGITS combination");
  end

  estado_t          estado;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_aj;
  logic [BIN_W-1:0] mag;
  logic [BIN_W-1:0] mag_in;
  logic             signo;
  logic             signo_in;

`ifdef BCD_SIGNO_EN
  // Two's-complement negation; the most negative value maps to its exact magnitude.
  assign signo_in = con_signo & bin[BIN_W-1];
  assign mag_in   = signo_in ? (~bin + BIN_W'(1)) : bin;
`else
  logic unused_con_signo;
  assign unused_con_signo = con_signo;
  assign signo_in = 1'b0;
  assign mag_in   = bin;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_ajuste
    bcd_ajuste_digito u_ajuste (
      .d (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (acc_aj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado     <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      mag        <= '0;
      signo      <= 1'b0;
      codigo_BCD <= '0;
      negativo   <= 1'b0;
      ocupado    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (estado)
        IDLE: begin
          if (inicio) begin
            mag     <= mag_in;
            signo   <= signo_in;
            acc     <= '0;
            cnt     <= CNT_W'(BIN_W);
            ocupado <= 1'b1;
            estado  <= CONVERT;
          end
        end
        CONVERT: begin
          {acc, mag} <= {acc_aj, mag} << 1;
          cnt        <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) estado <= FINISH;
        end
        FINISH: begin
          codigo_BCD <= acc;
          negativo   <= signo;
          done       <= 1'b1;
          ocupado    <= 1'b0;
          estado     <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bcd_convertidor_param.md
# bcd_convertidor_param

Parametrised, multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), with optional two's-complement input handling. It sits between the Booth multiplier product register and the 7-segment display driver. It converts a BIN_W-bit word into DIGITS packed BCD digits plus a sign flag. An `inicio`/`done` handshake and a busy indication let the controller sequence conversions.

## Interface
- BIN_W, 16: input word width, 2..32.
- DIGITS, 5: BCD output digits. The minimum is the number of digits of 2^BIN_W-1; a smaller value is an elaboration error.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- inicio  input  1  start request; sampled only in IDLE.
- bin  input  BIN_W  word to convert; captured on the accepted `inicio` edge.
- con_signo  input  1  1 = `bin` is two's complement; captured with `bin`.
- codigo_BCD  output  4*DIGITS  packed BCD result; digit 0 (units) occupies bits [3:0].
- negativo  output  1  sign of the last result.
- ocupado  output  1  conversion in progress.
- done  output  1  one-cycle pulse; result valid.

## Operation
- FSM states: IDLE, CONVERT, FINISH.
- IDLE:
  - When `inicio`=1, capture the magnitude into the shift register and the sign into a holding flop.
  - If con_signo=1 and bin[BIN_W-1]=1, the magnitude is -bin, formed as a BIN_W-bit unsigned value. -2^(BIN_W-1) yields 2^(BIN_W-1) exactly. Otherwise the magnitude is bin.
  - Clear the BCD accumulator, load the iteration counter with BIN_W, then go to CONVERT.
- CONVERT, each cycle:
  - Every accumulator digit ≥5 gets +3.
  - Then shift the {accumulator, magnitude} concatenation left by 1.
  - Decrement the counter; go to FINISH after iteration BIN_W.
- FINISH: load `codigo_BCD` and `negativo` from the accumulator and sign flop, pulse `done`, then return to IDLE.
- Outputs `codigo_BCD` and `negativo` hold their value until the next FINISH.
- `inicio` during CONVERT or FINISH is ignored; it is not queued.
- A zero result is never negative: sign flop = con_signo & bin[MSB], and a negative input is always nonzero.

## Timing
- Reset values: codigo_BCD=0, negativo=0, ocupado=0, done=0, state=IDLE, counter=0.
- Reset mid-conversion aborts immediately: no `done`, and outputs return to reset values.
- If `inicio` is accepted at edge E0, `done`=1 during the cycle after edge E0+BIN_W+1. Total latency is BIN_W+1 clocks (17 at default parameters).
- `ocupado`=1 from the cycle after E0 through the FINISH cycle inclusive.
- `done` falls in the next cycle. A new `inicio` in that first IDLE cycle is accepted, giving back-to-back throughput of one conversion per BIN_W+2 clocks.
- `inicio` held high continuously restarts a conversion at every IDLE cycle.
- reset=1 and inicio=1 on the same edge: reset wins.

## Configuration
- BCD_SIGNO_EN defined: signed handling as above.
- BCD_SIGNO_EN undefined:
  - `con_signo` is ignored; every input is treated as unsigned.
  - `negativo` is constant 0, and the negation logic is not synthesised.
  - The port list is unchanged.

## Structure
- Package `bcd_pkg`:
  - state enum (IDLE, CONVERT, FINISH);
  - constant BCD_DIGIT_W=4;
  - function `bcd_digitos_min(bin_w)`, used for the DIGITS legality check.
- Sub-module `bcd_ajuste_digito`: 4-bit combinational add-3-if-≥5 cell, generated DIGITS times.
- The counter is $clog2(BIN_W+1) bits.

## Test plan
- Unsigned: bin=16'h001C, con_signo=0 → codigo_BCD=20'h00028, negativo=0, done exactly 17 clocks after `inicio`.
- Max unsigned: bin=16'hFFFF, con_signo=0 → 20'h65535, negativo=0.
- Signed: bin=16'hFFFF, con_signo=1 → 20'h00001, negativo=1. bin=16'h8000, con_signo=1 → 20'h32768, negativo=1. bin=0 → 20'h00000, negativo=0.
- `inicio` pulsed at clocks 3 and 8 after a start of 16'h0457 → only one `done`, result 20'h01111. Back-to-back start on the cycle after `done` is accepted.
- reset asserted 6 clocks into a conversion → no `done`; codigo_BCD=0 and ocupado=0 on the next cycle. The next conversion of 16'h00FF → 20'h00255.
- Without BCD_SIGNO_EN: bin=16'hFFFF, con_signo=1 → 20'h65535, negativo=0. With BIN_W=8, DIGITS=3: 8'hFF → 12'h255 in 9 clocks.
